// File: rtl/gon_burst_gather.sv
// rtl/gon_burst_gather.sv - GON gather engine: tag FIFO, IDLE/XFER burst FSM, show-ahead data FIFO
module gon_burst_gather #(
    parameter int DATA_WIDTH      = 64,
    parameter int ROW_TAG_WIDTH   = 4,
    parameter int COL_TAG_WIDTH   = 4,
    parameter int BURST_WIDTH     = 8,
    parameter int NUM_OF_ROWS     = 12,
    parameter int NUM_OF_COLS     = 14,
    parameter int TAGS_FIFO_DEPTH = 16,
    parameter int DATA_FIFO_DEPTH = 64
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [ROW_TAG_WIDTH-1:0]                       row_tag,
    input  logic [COL_TAG_WIDTH-1:0]                       col_tag,
    input  logic [BURST_WIDTH-1:0]                         burst_len,
    input  logic                                           tags_wr_en,
    output logic                                           tags_full,
    input  logic [NUM_OF_ROWS*NUM_OF_COLS*DATA_WIDTH-1:0]  data_in,
    input  logic [NUM_OF_ROWS*NUM_OF_COLS-1:0]             ready_in,
    output logic [NUM_OF_ROWS*NUM_OF_COLS-1:0]             enable_out,
    output logic [DATA_WIDTH-1:0]                          data_out,
    input  logic                                           data_rd_en,
    output logic                                           data_empty,
    output logic [$clog2(DATA_FIFO_DEPTH):0]               data_count,
    output logic                                           busy,
    output logic                                           tag_error,
    input  logic                                           clear_error
);
    localparam int NUM_PE = NUM_OF_ROWS * NUM_OF_COLS;
    localparam int SEL_W  = $clog2(NUM_PE);
    localparam int DB_W   = $clog2(NUM_PE * DATA_WIDTH);
    localparam int TAG_W  = BURST_WIDTH + COL_TAG_WIDTH + ROW_TAG_WIDTH;
    localparam int TP_W   = $clog2(TAGS_FIFO_DEPTH) + 1;
    localparam int DP_W   = $clog2(DATA_FIFO_DEPTH) + 1;
    localparam int REM_W  = BURST_WIDTH + 1;

    typedef enum logic {IDLE, XFER} state_t;
    state_t state, state_next;

    // Tag FIFO
    logic [TAG_W-1:0] tag_mem [TAGS_FIFO_DEPTH];
    logic [TP_W-1:0]  tag_wr_ptr, tag_rd_ptr;
    logic             tag_empty, tag_push, tag_pop;
    logic [TAG_W-1:0] head;
    logic [ROW_TAG_WIDTH-1:0] head_row;
    logic [COL_TAG_WIDTH-1:0] head_col;
    logic [BURST_WIDTH-1:0]   head_len;
    logic             head_valid;

    assign tag_empty = (tag_wr_ptr == tag_rd_ptr);
    assign tags_full = (tag_wr_ptr[TP_W-1] != tag_rd_ptr[TP_W-1]) &&
                       (tag_wr_ptr[TP_W-2:0] == tag_rd_ptr[TP_W-2:0]);
    assign tag_push  = tags_wr_en & ~tags_full;
    assign head      = tag_mem[tag_rd_ptr[TP_W-2:0]];
    assign head_row  = head[ROW_TAG_WIDTH-1:0];
    assign head_col  = head[ROW_TAG_WIDTH +: COL_TAG_WIDTH];
    assign head_len  = head[ROW_TAG_WIDTH+COL_TAG_WIDTH +: BURST_WIDTH];
    assign head_valid = ({1'b0, head_row} < (ROW_TAG_WIDTH+1)'(NUM_OF_ROWS)) &&
                        ({1'b0, head_col} < (COL_TAG_WIDTH+1)'(NUM_OF_COLS));

    always_ff @(posedge clk) begin
        if (tag_push)
            tag_mem[tag_wr_ptr[TP_W-2:0]] <= {burst_len, col_tag, row_tag};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
        end else begin
            if (tag_push) tag_wr_ptr <= tag_wr_ptr + 1'b1;
            if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + 1'b1;
        end
    end

    // Burst datapath: the PE is addressed directly by row*cols+col
    logic [ROW_TAG_WIDTH-1:0] cur_row;
    logic [COL_TAG_WIDTH-1:0] cur_col;
    logic [REM_W-1:0]         remaining;
    logic [SEL_W-1:0]         sel;
    logic [DB_W-1:0]          data_base;
    logic [DATA_WIDTH-1:0]    beat_data;
    logic                     load, bad_tag, beat;

    assign sel       = SEL_W'(cur_row) * SEL_W'(NUM_OF_COLS) + SEL_W'(cur_col);
    assign data_base = DB_W'(sel) * DB_W'(DATA_WIDTH);
    assign beat_data = data_in[data_base +: DATA_WIDTH];

    // Data FIFO
    logic [DATA_WIDTH-1:0] data_mem [DATA_FIFO_DEPTH];
    logic [DP_W-1:0]       d_wr_ptr, d_rd_ptr;
    logic                  data_full, data_rd;

    assign data_empty = (d_wr_ptr == d_rd_ptr);
    assign data_full  = (d_wr_ptr[DP_W-1] != d_rd_ptr[DP_W-1]) &&
                        (d_wr_ptr[DP_W-2:0] == d_rd_ptr[DP_W-2:0]);
    assign data_rd    = data_rd_en & ~data_empty;
    assign data_count = d_wr_ptr - d_rd_ptr;
    assign data_out   = data_mem[d_rd_ptr[DP_W-2:0]];

    always_ff @(posedge clk) begin
        if (beat)
            data_mem[d_wr_ptr[DP_W-2:0]] <= beat_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_wr_ptr <= '0;
            d_rd_ptr <= '0;
        end else begin
            if (beat)    d_wr_ptr <= d_wr_ptr + 1'b1;
            if (data_rd) d_rd_ptr <= d_rd_ptr + 1'b1;
        end
    end

    // FSM
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!tag_empty && head_valid) state_next = XFER;
            XFER: if (beat && remaining == REM_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tag_pop    = 1'b0;
        load       = 1'b0;
        bad_tag    = 1'b0;
        beat       = 1'b0;
        enable_out = '0;
        case (state)
            IDLE: begin
                tag_pop = ~tag_empty;
                load    = ~tag_empty & head_valid;
                bad_tag = ~tag_empty & ~head_valid;
            end
            XFER: begin
                beat            = ready_in[sel] & ~data_full;
                enable_out[sel] = beat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_row   <= '0;
            cur_col   <= '0;
            remaining <= '0;
        end else if (load) begin
            cur_row   <= head_row;
            cur_col   <= head_col;
            remaining <= REM_W'(head_len) + REM_W'(1);
        end else if (beat) begin
            remaining <= remaining - REM_W'(1);
        end
    end

    // A dropped tag in the same cycle as clear_error keeps the flag set
    always_ff @(posedge clk) begin
        if (!reset)           tag_error <= 1'b0;
        else if (bad_tag)     tag_error <= 1'b1;
        else if (clear_error) tag_error <= 1'b0;
    end

    assign busy = (state != IDLE) || !tag_empty;

endmodule

// File: tb/tb_gon_burst_gather.sv
// tb/tb_gon_burst_gather.sv - randomized scoreboard bench for gon_burst_gather
module tb_gon_burst_gather;
    localparam int DW  = 64;
    localparam int NR  = 12;
    localparam int NC  = 14;
    localparam int NPE = NR * NC;
    localparam int DFD = 4;

    logic clk = 1'b0;
    logic resetn;
    logic [3:0] row_tag, col_tag;
    logic [7:0] burst_len;
    logic tags_wr_en, tags_full;
    logic [NPE*DW-1:0] data_in;
    logic [NPE-1:0] ready_in, enable_out;
    logic [DW-1:0] data_out;
    logic data_rd_en, data_empty;
    logic [2:0] data_count;
    logic busy, tag_error, clear_error;

    int checks = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];
    int pe_seq[NPE];
    int exp_seq[NPE];
    int ready_mode = 1;
    int rd_mode = 0;
    int en_count = 0;
    bit cnt_watch = 0;

    gon_burst_gather #(.DATA_FIFO_DEPTH(DFD)) dut (
        .clk(clk), .reset(resetn), .row_tag(row_tag), .col_tag(col_tag),
        .burst_len(burst_len), .tags_wr_en(tags_wr_en), .tags_full(tags_full),
        .data_in(data_in), .ready_in(ready_in), .enable_out(enable_out),
        .data_out(data_out), .data_rd_en(data_rd_en), .data_empty(data_empty),
        .data_count(data_count), .busy(busy), .tag_error(tag_error),
        .clear_error(clear_error)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int p, input int s);
        return {16'hB0A7, p[15:0], s[31:0]};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a valid tag yields burst_len+1 consecutive words of that PE's stream
    function automatic bit model_tag(input int r, input int c, input int l);
        int p;
        if (r >= NR || c >= NC) return 1'b0;
        p = r * NC + c;
        for (int i = 0; i <= l; i++) begin
            exp_q.push_back(word(p, exp_seq[p]));
            exp_seq[p]++;
        end
        return 1'b1;
    endfunction

    task automatic push_tag(input int r, input int c, input int l, input bit accepted);
        bit v;
        @(posedge clk); #2;
        row_tag = r[3:0]; col_tag = c[3:0]; burst_len = l[7:0]; tags_wr_en = 1'b1;
        if (accepted) v = model_tag(r, c, l);
        @(posedge clk); #2;
        tags_wr_en = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name);
        int n = 0;
        rd_mode = 1;
        while ((busy || !data_empty) && n < 3000) begin
            @(posedge clk); n++;
        end
        #2;
        check({name, "_drain_done"}, n < 3000, 1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // PE array model plus read-enable driver
    initial begin
        logic [NPE-1:0] snap;
        for (int p = 0; p < NPE; p++) data_in[p*DW +: DW] = word(p, 0);
        ready_in = '1;
        data_rd_en = 1'b0;
        forever begin
            @(negedge clk);
            snap = enable_out;
            @(posedge clk); #1;
            for (int p = 0; p < NPE; p++)
                if (snap[p]) begin
                    pe_seq[p]++;
                    data_in[p*DW +: DW] = word(p, pe_seq[p]);
                end
            if (ready_mode == 0) ready_in = '0;
            else if (ready_mode == 1) ready_in = '1;
            else for (int p = 0; p < NPE; p++) ready_in[p] = $urandom_range(0, 3) != 0;
            data_rd_en = (rd_mode == 1) ? 1'b1 : (rd_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every accepted read
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                check("enable_legal", ($countones(enable_out) <= 1) && ((enable_out & ~ready_in) == '0), 1);
                if (|enable_out) en_count++;
                if (cnt_watch) check("count_le1", data_count <= 3'd1, 1);
                if (data_rd_en && !data_empty) begin
                    if (exp_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_word: got %0h expected none", data_out);
                    end else begin
                        check("data_order", data_out, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] pat;
        int e0, sum, n, r, c, l;
        bit any_bad, v;
        resetn = 1'b0; tags_wr_en = 1'b0; clear_error = 1'b0;
        row_tag = '0; col_tag = '0; burst_len = '0;
        cycles(3);
        resetn = 1'b1;
        check("init_empty", data_empty, 1);
        check("init_busy", busy, 0);

        // Reset with a tag error, stalled burst and a pending tag
        push_tag(13, 0, 0, 1'b0);
        push_tag(2, 2, 5, 1'b1);
        push_tag(4, 4, 1, 1'b1);
        cycles(10);
        check("pre_reset_error", tag_error, 1);
        check("pre_reset_count", data_count, 4);
        resetn = 1'b0;
        cycles(2);
        check("rst_enable", enable_out, 0);
        check("rst_tags_full", tags_full, 0);
        check("rst_data_empty", data_empty, 1);
        check("rst_data_count", data_count, 0);
        check("rst_busy", busy, 0);
        check("rst_tag_error", tag_error, 0);
        resetn = 1'b1;
        exp_q.delete();
        for (int p = 0; p < NPE; p++) exp_seq[p] = pe_seq[p];
        cycles(2);
        check("post_rst_busy", busy, 0);
        check("post_rst_empty", data_empty, 1);

        // Single burst: enable window 2 cycles after push, 4 cycles wide
        @(posedge clk); #2;
        row_tag = 4'd3; col_tag = 4'd5; burst_len = 8'd3; tags_wr_en = 1'b1;
        v = model_tag(3, 5, 3);
        pat = '0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            pat = {pat[5:0], enable_out[3*NC+5]};
            if (k == 0) begin
                @(posedge clk); #2;
                tags_wr_en = 1'b0;
            end
        end
        check("single_enable_window", pat, 7'b0011110);
        drain("single");
        check("single_busy_low", busy, 0);

        // Backpressure with a 4-deep data FIFO
        rd_mode = 0;
        cycles(2);
        e0 = en_count;
        push_tag(1, 2, 7, 1'b1);
        cycles(12);
        check("bp_beats", en_count - e0, 4);
        check("bp_count", data_count, 4);
        rd_mode = 1;
        cycles(1);
        rd_mode = 0;
        cycles(6);
        check("bp_one_more", en_count - e0, 5);
        check("bp_count_refill", data_count, 4);
        drain("bp");

        // Invalid tag then a valid one
        e0 = en_count;
        push_tag(12, 0, 0, 1'b1);
        push_tag(0, 0, 0, 1'b1);
        cycles(8);
        check("inv_error", tag_error, 1);
        check("inv_beats", en_count - e0, 1);
        drain("inv");
        clear_error = 1'b1;
        cycles(1);
        clear_error = 1'b0;
        check("inv_cleared", tag_error, 0);

        // Tag FIFO full while the FSM is stalled on ready
        ready_mode = 0;
        cycles(3);
        e0 = en_count;
        sum = 0;
        for (int i = 0; i < 18; i++) begin
            r = $urandom_range(0, NR-1); c = $urandom_range(0, NC-1); l = $urandom_range(0, 2);
            if (i < 17) sum += l + 1;
            push_tag(r, c, l, i < 17);
        end
        check("full_flag", tags_full, 1);
        check("full_no_beats", en_count - e0, 0);
        ready_mode = 1;
        drain("full");
        check("full_beats", en_count - e0, sum);
        check("full_flag_clear", tags_full, 0);

        // Continuous read: simultaneous read/write, pointer wrap
        rd_mode = 1;
        cycles(2);
        cnt_watch = 1;
        for (int i = 0; i < 3; i++) push_tag(7, 13, 3, 1'b1);
        drain("wrap");
        cnt_watch = 0;

        // Randomized batches
        ready_mode = 2;
        for (int b = 0; b < 10; b++) begin
            rd_mode = 2;
            any_bad = 0;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 13); c = $urandom_range(0, 15); l = $urandom_range(0, 5);
                if (r >= NR || c >= NC) any_bad = 1;
                push_tag(r, c, l, 1'b1);
                if ($urandom_range(0, 1) == 1) cycles($urandom_range(1, 4));
            end
            drain("rand");
            check("rand_tag_error", tag_error, any_bad);
            clear_error = 1'b1;
            cycles(1);
            clear_error = 1'b0;
        end

        cycles(3);
        check("final_queue", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
